// File: rtl/result_ram_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : result_ram_reader_if
//  Purpose  : Bundles the result_ram_reader control, Result RAM read port and
//             output word stream into a single interface.
//  Ports    : control   - Start, Width_count, Filter_count, Relu_en, Busy, Done
//             RAM read  - Result_RAM_read_address_depth/_width,
//                         Result_RAM_read_enable, Result_RAM_read_data
//             stream    - Out_data, Out_valid, Out_ready, Out_last
//             slave  modport : the reader block itself
//             master modport : the surrounding logic (controller, RAM, sink)
//  Revision : 1.0 - initial release
// ============================================================================
interface result_ram_reader_if #(
   parameter int BIT_WIDTH                  = 16,
   parameter int DATASET_DEPTH_COUNTER_BITS = 9,
   parameter int FILTER_COUNTER_BITS        = 3
) ();

   logic                                  Start;
   logic [DATASET_DEPTH_COUNTER_BITS:0]   Width_count;
   logic [FILTER_COUNTER_BITS:0]          Filter_count;
   logic                                  Relu_en;
   logic [FILTER_COUNTER_BITS-1:0]        Result_RAM_read_address_depth;
   logic [DATASET_DEPTH_COUNTER_BITS-1:0] Result_RAM_read_address_width;
   logic                                  Result_RAM_read_enable;
   logic [BIT_WIDTH-1:0]                  Result_RAM_read_data;
   logic [BIT_WIDTH-1:0]                  Out_data;
   logic                                  Out_valid;
   logic                                  Out_ready;
   logic                                  Out_last;
   logic                                  Busy;
   logic                                  Done;

   modport slave (
      input  Start, Width_count, Filter_count, Relu_en,
      input  Result_RAM_read_data, Out_ready,
      output Result_RAM_read_address_depth, Result_RAM_read_address_width,
      output Result_RAM_read_enable,
      output Out_data, Out_valid, Out_last, Busy, Done
   );

   modport master (
      output Start, Width_count, Filter_count, Relu_en,
      output Result_RAM_read_data, Out_ready,
      input  Result_RAM_read_address_depth, Result_RAM_read_address_width,
      input  Result_RAM_read_enable,
      input  Out_data, Out_valid, Out_last, Busy, Done
   );

endinterface
`default_nettype wire

// File: rtl/result_ram_reader.sv
`default_nettype none
// ============================================================================
//  Module   : result_ram_reader
//  Purpose  : Drains a finished layer result from the Result RAM after Start
//             and streams it position-major / filter-minor as valid/ready
//             words, with optional ReLU clamp on the way out.
//  Ports    : Clk     - clock, rising edge
//             Reset_n - asynchronous active-low reset
//             bus     - result_ram_reader_if.slave (control, RAM read port,
//                       output stream, Busy/Done status)
//  Revision : 1.0 - initial release
// ============================================================================
module result_ram_reader #(
   parameter int BIT_WIDTH                  = 16,
   parameter int DATASET_DEPTH_COUNTER_BITS = 9,
   parameter int FILTER_COUNTER_BITS        = 3
) (
   input  logic               Clk,
   input  logic               Reset_n,
   result_ram_reader_if.slave bus
);

   localparam int c_wcnt_bits = DATASET_DEPTH_COUNTER_BITS + 1;
   localparam int c_fcnt_bits = FILTER_COUNTER_BITS + 1;
   localparam logic [c_wcnt_bits-1:0]                c_wcnt_one = 1;
   localparam logic [c_fcnt_bits-1:0]                c_fcnt_one = 1;
   localparam logic [FILTER_COUNTER_BITS-1:0]        c_fidx_one = 1;
   localparam logic [DATASET_DEPTH_COUNTER_BITS-1:0] c_pos_one  = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                                state_q, state_d;
   logic [c_wcnt_bits-1:0]                wcnt_q, wcnt_d;
   logic [c_fcnt_bits-1:0]                fcnt_q, fcnt_d;
   logic                                  relu_q, relu_d;
   logic [FILTER_COUNTER_BITS-1:0]        fidx_q, fidx_d;     // next filter index to read
   logic [DATASET_DEPTH_COUNTER_BITS-1:0] pos_q, pos_d;       // next position to read
   logic [FILTER_COUNTER_BITS-1:0]        fhold_q, fhold_d;   // last issued address
   logic [DATASET_DEPTH_COUNTER_BITS-1:0] phold_q, phold_d;
   logic                                  dvld_q, dvld_d;     // RAM data arrives this cycle
   logic                                  dlast_q, dlast_d;   // ...and it is the final word
   logic [BIT_WIDTH-1:0]                  e0_q, e0_d, e1_q, e1_d;
   logic                                  l0_q, l0_d, l1_q, l1_d;
   logic [1:0]                            cnt_q, cnt_d;

   logic                 w_pop;
   logic [2:0]           w_occ;
   logic                 w_fidx_end;
   logic                 w_is_last;
   logic                 w_rd_en;
   logic                 w_busy;
   logic                 w_done;
   logic [BIT_WIDTH-1:0] w_wdata;

   assign w_pop      = (cnt_q != 2'd0) && bus.Out_ready;
   // Words owned by the block once this cycle's transfer is taken out. A new
   // read is safe when this is below 2: its data lands two edges later, by
   // which time at most two words can be held even if nothing else drains.
   assign w_occ      = {1'b0, cnt_q} + {2'b00, dvld_q} - {2'b00, w_pop};
   assign w_fidx_end = ({1'b0, fidx_q} == (fcnt_q - c_fcnt_one));
   assign w_is_last  = w_fidx_end && ({1'b0, pos_q} == (wcnt_q - c_wcnt_one));
   assign w_wdata    = (relu_q && bus.Result_RAM_read_data[BIT_WIDTH-1]) ?
                       '0 : bus.Result_RAM_read_data;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      fcnt_d  = fcnt_q;
      relu_d  = relu_q;
      fidx_d  = fidx_q;
      pos_d   = pos_q;
      w_rd_en = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               wcnt_d = bus.Width_count;
               fcnt_d = bus.Filter_count;
               relu_d = bus.Relu_en;
               fidx_d = '0;
               pos_d  = '0;
               if ((bus.Width_count == '0) || (bus.Filter_count == '0)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            w_busy = 1'b1;
            if (w_occ < 3'd2) begin
               w_rd_en = 1'b1;
               if (w_is_last) begin
                  state_d = S_FLUSH;
               end else if (w_fidx_end) begin
                  fidx_d = '0;
                  pos_d  = pos_q + c_pos_one;
               end else begin
                  fidx_d = fidx_q + c_fidx_one;
               end
            end
         end
         S_FLUSH: begin
            w_busy = 1'b1;
            if (w_occ == 3'd0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            w_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dvld_d  = w_rd_en;
   assign dlast_d = w_rd_en && w_is_last;
   assign fhold_d = w_rd_en ? fidx_q : fhold_q;
   assign phold_d = w_rd_en ? pos_q  : phold_q;

   // Two-entry FWFT buffer, entry 0 is the head presented on the stream.
   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      l0_d  = l0_q;
      l1_d  = l1_q;
      if (w_pop) begin
         e0_d = e1_q;
         l0_d = l1_q;
      end
      if (dvld_q) begin
         if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && w_pop)) begin
            e0_d = w_wdata;
            l0_d = dlast_q;
         end else begin
            e1_d = w_wdata;
            l1_d = dlast_q;
         end
      end
      cnt_d = cnt_q + {1'b0, dvld_q} - {1'b0, w_pop};
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         fcnt_q  <= '0;
         relu_q  <= 1'b0;
         fidx_q  <= '0;
         pos_q   <= '0;
         fhold_q <= '0;
         phold_q <= '0;
         dvld_q  <= 1'b0;
         dlast_q <= 1'b0;
         e0_q    <= '0;
         e1_q    <= '0;
         l0_q    <= 1'b0;
         l1_q    <= 1'b0;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         fcnt_q  <= fcnt_d;
         relu_q  <= relu_d;
         fidx_q  <= fidx_d;
         pos_q   <= pos_d;
         fhold_q <= fhold_d;
         phold_q <= phold_d;
         dvld_q  <= dvld_d;
         dlast_q <= dlast_d;
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         l0_q    <= l0_d;
         l1_q    <= l1_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.Result_RAM_read_enable        = w_rd_en;
   assign bus.Result_RAM_read_address_depth = w_rd_en ? fidx_q : fhold_q;
   assign bus.Result_RAM_read_address_width = w_rd_en ? pos_q  : phold_q;
   assign bus.Out_data                      = e0_q;
   assign bus.Out_valid                     = (cnt_q != 2'd0);
   assign bus.Out_last                      = l0_q && (cnt_q != 2'd0);
   assign bus.Busy                          = w_busy;
   assign bus.Done                          = w_done;

endmodule
`default_nettype wire

// File: tb/tb_result_ram_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_ram_reader
//  Purpose  : Self-checking bench for result_ram_reader. A RAM model answers
//             reads one cycle later; a queue of expected words is built from
//             the drain rules and compared against every stream transfer.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_ram_reader;

   localparam int BW  = 16;
   localparam int DSB = 9;
   localparam int FB  = 3;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b0;

   result_ram_reader_if #(.BIT_WIDTH(BW), .DATASET_DEPTH_COUNTER_BITS(DSB),
                          .FILTER_COUNTER_BITS(FB)) bus ();

   result_ram_reader #(.BIT_WIDTH(BW), .DATASET_DEPTH_COUNTER_BITS(DSB),
                       .FILTER_COUNTER_BITS(FB)) u_dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   logic [BW-1:0] mem [0:7][0:511];

   always @(posedge Clk) begin
      if (bus.Result_RAM_read_enable)
         bus.Result_RAM_read_data <= mem[bus.Result_RAM_read_address_depth]
                                        [bus.Result_RAM_read_address_width];
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ready_mode = 0;          // 0 always, 1 pattern 1,0,0, 2 random, 3 never
   int done_cnt = 0;
   int done_cyc = 0;
   int first_valid_cyc = 0;
   int last_xfer_cyc = 0;
   int rd_idx = 0;
   int n_issued = 0;
   int n_xfer = 0;
   int drain_total = 0;
   int drain_f = 1;
   int last_rd_d = -1;
   int last_rd_w = -1;
   bit seen_valid = 0;
   bit prev_stall = 0;
   logic [BW-1:0] prev_data;
   logic          prev_last;
   logic [BW:0]   exp_q [$];     // {last, data}

   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // cycle counter and Out_ready driver
   initial begin
      bus.Out_ready = 1'b1;
      forever begin
         @(posedge Clk);
         cyc++;
         #1;
         case (ready_mode)
            0:       bus.Out_ready = 1'b1;
            1:       bus.Out_ready = ((cyc % 3) == 0);
            2:       bus.Out_ready = ($urandom_range(0, 3) != 0);
            default: bus.Out_ready = 1'b0;
         endcase
      end
   end

   // stream / read-port monitor
   initial begin
      logic [BW:0] e;
      forever begin
         @(negedge Clk);
         if (!Reset_n) begin
            prev_stall = 0;
            seen_valid = 0;
            rd_idx     = 0;
            n_issued   = 0;
            n_xfer     = 0;
         end else begin
            if (prev_stall) begin
               check_value("stall_valid", bus.Out_valid, 1);
               check_value("stall_data", bus.Out_data, prev_data);
               check_value("stall_last", bus.Out_last, prev_last);
            end
            if (bus.Out_valid && !seen_valid) begin
               seen_valid = 1;
               first_valid_cyc = cyc;
            end
            if (bus.Out_valid)
               check_value("valid_has_word", exp_q.size() != 0, 1);
            if (bus.Out_valid && bus.Out_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_value("out_data", bus.Out_data, e[BW-1:0]);
               check_value("out_last", bus.Out_last, e[BW]);
               n_xfer++;
               last_xfer_cyc = cyc;
            end
            if (bus.Result_RAM_read_enable) begin
               check_value("rd_in_drain", rd_idx < drain_total, 1);
               check_value("rd_occupancy", (n_issued - n_xfer) < 2, 1);
               if (rd_idx < drain_total) begin
                  check_value("rd_addr_d", bus.Result_RAM_read_address_depth, rd_idx % drain_f);
                  check_value("rd_addr_w", bus.Result_RAM_read_address_width, rd_idx / drain_f);
               end
               last_rd_d = bus.Result_RAM_read_address_depth;
               last_rd_w = bus.Result_RAM_read_address_width;
               rd_idx++;
               n_issued++;
            end
            if (bus.Done) begin
               done_cnt++;
               done_cyc   = cyc;
               rd_idx     = 0;
               n_issued   = 0;
               n_xfer     = 0;
               seen_valid = 0;
            end
            prev_stall = bus.Out_valid && !bus.Out_ready;
            prev_data  = bus.Out_data;
            prev_last  = bus.Out_last;
         end
      end
   end

   task automatic build_expect(input int w_n, input int f_n, input bit relu);
      logic [BW-1:0] v;
      exp_q.delete();
      for (int w = 0; w < w_n; w++) begin
         for (int d = 0; d < f_n; d++) begin
            v = mem[d][w];
            if (relu && v[BW-1]) v = '0;
            exp_q.push_back({((w == w_n - 1) && (d == f_n - 1)), v});
         end
      end
      drain_total = w_n * f_n;
      drain_f     = (f_n == 0) ? 1 : f_n;
   endtask

   task automatic pulse_start(input int w_n, input int f_n, input bit relu, output int s);
      @(posedge Clk); #1;
      bus.Start        = 1'b1;
      bus.Width_count  = 10'(w_n);
      bus.Filter_count = 4'(f_n);
      bus.Relu_en      = relu;
      s = cyc;
      @(posedge Clk); #1;
      bus.Start        = 1'b0;
      bus.Width_count  = 10'($urandom);
      bus.Filter_count = 4'($urandom);
      bus.Relu_en      = ~relu;
   endtask

   task automatic run_drain(input int w_n, input int f_n, input bit relu,
                            input int mode, input int poke_at);
      int s;
      int snap;
      bit got;
      ready_mode = mode;
      build_expect(w_n, f_n, relu);
      snap = done_cnt;
      pulse_start(w_n, f_n, relu, s);
      check_value("busy_after_start", bus.Busy, (w_n * f_n) != 0);
      got = 0;
      for (int i = 0; (i < w_n * f_n * 6 + 40) && !got; i++) begin
         if (i == poke_at) begin
            bus.Start        = 1'b1;
            bus.Width_count  = 10'd1;
            bus.Filter_count = 4'd1;
         end else begin
            bus.Start = 1'b0;
         end
         @(posedge Clk); #1;
         if (done_cnt != snap) got = 1;
      end
      bus.Start = 1'b0;
      check_value("done_seen", got, 1);
      if (w_n * f_n != 0) begin
         check_value("first_valid_latency", first_valid_cyc - s, 3);
         check_value("done_after_last", done_cyc - last_xfer_cyc, 1);
      end
      repeat (3) @(posedge Clk);
      #1;
      check_value("done_once", done_cnt - snap, 1);
      check_value("words_left", exp_q.size(), 0);
      check_value("busy_idle", bus.Busy, 0);
   endtask

   initial begin
      int s;
      int snap;
      bus.Start        = 1'b0;
      bus.Width_count  = '0;
      bus.Filter_count = '0;
      bus.Relu_en      = 1'b0;
      Reset_n          = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check_value("rst_out_valid", bus.Out_valid, 0);
      check_value("rst_out_last", bus.Out_last, 0);
      check_value("rst_out_data", bus.Out_data, 0);
      check_value("rst_busy", bus.Busy, 0);
      check_value("rst_done", bus.Done, 0);
      check_value("rst_rd_en", bus.Result_RAM_read_enable, 0);
      check_value("rst_addr_d", bus.Result_RAM_read_address_depth, 0);
      check_value("rst_addr_w", bus.Result_RAM_read_address_width, 0);
      Reset_n = 1'b1;

      // 16*w+d pattern, full rate then throttled
      for (int d = 0; d < 8; d++)
         for (int w = 0; w < 512; w++)
            mem[d][w] = 16'((16 * w + d) & 16'hFFFF);
      run_drain(3, 2, 1'b0, 0, -1);
      run_drain(3, 2, 1'b0, 1, -1);

      // ReLU boundary values
      mem[0][0] = 16'h8000; mem[0][1] = 16'hFFFF;
      mem[0][2] = 16'h7FFF; mem[0][3] = 16'h0001;
      run_drain(4, 1, 1'b1, 0, -1);
      run_drain(4, 1, 1'b0, 2, -1);

      // empty drains
      run_drain(0, 6, 1'b0, 0, -1);
      run_drain(5, 0, 1'b1, 0, -1);

      // full RAM with a second Start while busy
      for (int d = 0; d < 8; d++)
         for (int w = 0; w < 512; w++)
            mem[d][w] = 16'($urandom);
      run_drain(512, 8, 1'b1, 2, 300);
      check_value("last_rd_d", last_rd_d, 7);
      check_value("last_rd_w", last_rd_w, 511);
      check_value("hold_addr_d", bus.Result_RAM_read_address_depth, 7);
      check_value("hold_addr_w", bus.Result_RAM_read_address_width, 511);

      // random shapes
      for (int k = 0; k < 4; k++)
         run_drain($urandom_range(1, 20), $urandom_range(1, 8), 1'($urandom), 2, -1);

      // abort mid-stream with the sink stalled
      ready_mode = 3;
      build_expect(4, 3, 1'b0);
      snap = done_cnt;
      pulse_start(4, 3, 1'b0, s);
      repeat (8) @(posedge Clk);
      #1;
      Reset_n = 1'b0;
      #1;
      check_value("abort_out_valid", bus.Out_valid, 0);
      check_value("abort_out_data", bus.Out_data, 0);
      check_value("abort_out_last", bus.Out_last, 0);
      check_value("abort_busy", bus.Busy, 0);
      check_value("abort_rd_en", bus.Result_RAM_read_enable, 0);
      exp_q.delete();
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      check_value("abort_no_done", done_cnt - snap, 0);
      for (int d = 0; d < 8; d++)
         for (int w = 0; w < 512; w++)
            mem[d][w] = 16'($urandom);
      run_drain(4, 3, 1'b0, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
